// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the E stage and the multiply/divide unit.
// The master drives the operation request and HI/LO read select; the slave returns status and HI/LO.
interface mult_div_unit_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        HiLoSel;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] RD;

    modport master (
        output Start, MDOp, A, B, HiLoSel,
        input  Busy, HI, LO, RD
    );

    modport slave (
        input  Start, MDOp, A, B, HiLoSel,
        output Busy, HI, LO, RD
    );
endinterface

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit owning HI/LO. The result is computed at launch into a
// pending register and committed after a fixed Busy window, mimicking a multi-cycle unit.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_unit_if.slave   md
);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state, w_next_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi, r_lo;
    logic [31:0] r_pend_hi, r_pend_lo;
    logic        r_pend_wr;
    logic        w_busy, w_launch, w_done;

    logic [63:0] w_prod_s, w_prod_u, w_prod;
    logic        w_signed_div, w_a_neg, w_b_neg, w_b_zero;
    logic [31:0] w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_quot, w_rem;
    logic [63:0] w_result;

    // Explicit 64-bit extension keeps the product width independent of operator context rules.
    assign w_prod_s = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
    assign w_prod_u = {32'd0, md.A} * {32'd0, md.B};
    assign w_prod   = (md.MDOp == OP_MULT) ? w_prod_s : w_prod_u;

    // Signed divide through magnitudes: 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign w_signed_div = (md.MDOp == OP_DIV);
    assign w_a_neg      = w_signed_div & md.A[31];
    assign w_b_neg      = w_signed_div & md.B[31];
    assign w_a_mag      = w_a_neg ? (32'd0 - md.A) : md.A;
    assign w_b_mag      = w_b_neg ? (32'd0 - md.B) : md.B;
    assign w_b_zero     = (md.B == 32'd0);
    assign w_q_mag      = w_b_zero ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_r_mag      = w_b_zero ? 32'd0 : (w_a_mag % w_b_mag);
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    assign w_result = md.MDOp[1] ? {w_rem, w_quot} : w_prod;

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_launch     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (md.Start && !md.MDOp[2]) begin
                    w_launch     = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (r_cnt == 4'd1) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_launch) begin
                r_pend_hi <= w_result[63:32];
                r_pend_lo <= w_result[31:0];
                // Divide by zero still runs the Busy window but leaves HI/LO untouched.
                r_pend_wr <= !(md.MDOp[1] && w_b_zero);
                r_cnt     <= md.MDOp[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            end else if (w_busy) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_done && r_pend_wr) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
            if (r_state == S_IDLE && md.Start) begin
                if (md.MDOp == OP_MTHI) r_hi <= md.A;
                if (md.MDOp == OP_MTLO) r_lo <= md.A;
            end
        end
    end

    assign md.Busy = w_busy;
    assign md.HI   = r_hi;
    assign md.LO   = r_lo;
    assign md.RD   = md.HiLoSel ? r_hi : r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/Busy-length queued at launch,
// popped and compared in the first cycle after Busy falls.
module tb_mult_div_unit;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi, m_lo;

    mult_div_unit_if md_if();

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_rd(input string tag);
        md_if.HiLoSel = 1'b1;
        #1 chk({tag, "_rd_hi"}, md_if.RD, m_hi);
        md_if.HiLoSel = 1'b0;
        #1 chk({tag, "_rd_lo"}, md_if.RD, m_lo);
    endtask

    task automatic pulse(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        md_if.Start = 1'b1;
        md_if.MDOp  = op;
        md_if.A     = a;
        md_if.B     = b;
        @(negedge clk);
        md_if.Start = 1'b0;
    endtask

    // inj > 0 fires an mthi 0xDEAD while Busy, on that Busy cycle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int en, input int inj);
        exp_t e;
        int   n;
        e.hi = ehi; e.lo = elo; e.n = en;
        sb.push_back(e);
        pulse(op, a, b);
        n = 0;
        while (md_if.Busy === 1'b1 && n < 40) begin
            chk({tag, "_hold_hi"}, md_if.HI, m_hi);
            chk({tag, "_hold_lo"}, md_if.LO, m_lo);
            n++;
            if (n == inj) begin
                md_if.Start = 1'b1;
                md_if.MDOp  = 3'b100;
                md_if.A     = 32'h0000_DEAD;
            end
            @(negedge clk);
            md_if.Start = 1'b0;
        end
        e = sb.pop_front();
        chk({tag, "_busy_cycles"}, 32'(n), 32'(e.n));
        chk({tag, "_hi"}, md_if.HI, e.hi);
        chk({tag, "_lo"}, md_if.LO, e.lo);
        m_hi = e.hi;
        m_lo = e.lo;
        chk_rd(tag);
    endtask

    initial begin
        exp_t e;
        int   n;
        n_chk = 0; n_fail = 0;
        m_hi = 32'd0; m_lo = 32'd0;
        reset = 1'b1;
        md_if.Start = 1'b0; md_if.MDOp = 3'b000;
        md_if.A = 32'd0; md_if.B = 32'd0; md_if.HiLoSel = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(md_if.Busy), 32'd0);
        chk("rst_hi", md_if.HI, 32'd0);
        chk("rst_lo", md_if.LO, 32'd0);
        chk_rd("rst");

        run_op("mult",  3'b000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 0);
        run_op("multu", 3'b001, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5, 0);
        run_op("div",   3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0);
        run_op("divu",  3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 10, 0);

        pulse(3'b100, 32'h11, 32'd0);
        chk("mthi_busy", 32'(md_if.Busy), 32'd0);
        m_hi = 32'h11;
        chk_rd("mthi");
        pulse(3'b101, 32'h22, 32'd0);
        chk("mtlo_busy", 32'(md_if.Busy), 32'd0);
        m_lo = 32'h22;
        chk_rd("mtlo");

        pulse(3'b110, 32'h55, 32'h66);
        chk("rsvd_busy", 32'(md_if.Busy), 32'd0);
        chk("rsvd_hi", md_if.HI, m_hi);
        chk("rsvd_lo", md_if.LO, m_lo);

        run_op("divu0", 3'b011, 32'd50, 32'd0, 32'h11, 32'h22, 10, 0);
        run_op("divovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 0);
        run_op("mult_ign", 3'b000, 32'd6, 32'd7, 32'd0, 32'd42, 5, 2);

        // Reset partway through a divide: state and HI/LO clear.
        e.hi = 32'd0; e.lo = 32'd0; e.n = 4;
        sb.push_back(e);
        pulse(3'b010, 32'd100, 32'd7);
        n = 0;
        while (md_if.Busy === 1'b1 && n < 4) begin
            n++;
            if (n < 4) @(negedge clk);
        end
        e = sb.pop_front();
        chk("rstrun_busy_cycles", 32'(n), 32'(e.n));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstrun_busy", 32'(md_if.Busy), 32'd0);
        chk("rstrun_hi", md_if.HI, e.hi);
        chk("rstrun_lo", md_if.LO, e.lo);
        m_hi = 32'd0; m_lo = 32'd0;

        run_op("mult33", 3'b000, 32'd3, 32'd3, 32'd0, 32'd9, 5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
